// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin share of one block memory between icache and dcache.
// Ports: i_* icache side, d_* dcache side, mem_* memory side; clk, reset (async, high).
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } state_e;

  state_e state, state_nxt;
  logic started, started_nxt;
  logic last_d, last_d_nxt;
  logic req_i, req_d, done;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  assign req_i = i_read;
  assign req_d = d_read | d_write;
  assign done  = (state != IDLE) & started & ~mem_busywait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      started   <= 1'b0;
      last_d    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      started <= started_nxt;
      last_d  <= last_d_nxt;
      if (state == GRANT_I && done)
        i_rdata_q <= mem_readdata;
      if (state == GRANT_D && done)
        d_rdata_q <= mem_readdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    unique case (state)
      IDLE: begin
        if (req_i && req_d)
          state_nxt = last_d ? GRANT_I : GRANT_D;
        else if (req_i)
          state_nxt = GRANT_I;
        else if (req_d)
          state_nxt = GRANT_D;
      end
      GRANT_I: begin
        if (done) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b0;
        end else if (!req_i && !started) begin
          // withdrawn before memory accepted: no completion
          state_nxt = IDLE;
        end
      end
      GRANT_D: begin
        if (done) begin
          state_nxt  = IDLE;
          last_d_nxt = 1'b1;
        end else if (!req_d && !started) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    started_nxt = started;
    if (state_nxt == IDLE)
      started_nxt = 1'b0;
    else if (state != IDLE && mem_busywait)
      started_nxt = 1'b1;
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      GRANT_I: begin
        mem_read    = i_read;
        mem_address = i_address;
      end
      GRANT_D: begin
        // read+write together is treated as a write
        mem_write     = d_write;
        mem_read      = d_read & ~d_write;
        mem_address   = d_address;
        mem_writedata = d_writedata;
      end
      default: ;
    endcase
  end

  assign i_busywait = req_i & ~(state == GRANT_I & done);
  assign d_busywait = req_d & ~(state == GRANT_D & done);

  assign i_readdata = (state == GRANT_I) ? mem_readdata : i_rdata_q;
  assign d_readdata = (state == GRANT_D) ? mem_readdata : d_rdata_q;

endmodule
